// File: rtl/t05_wb_manager_if.sv
// Wishbone B4 classic bus between the manager and the SRAM wrapper.
// The master drives the cycle; the slave returns read data and ACK.
interface t05_wb_manager_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/t05_wb_manager.sv
// Single-outstanding Wishbone classic master: one level request in, one bus
// cycle out, completed by ACK_I or aborted by a watchdog.
module t05_wb_manager #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    r_en,
  input  logic [3:0]              select,
  input  logic [31:0]             addr,
  input  logic [31:0]             data_i,
  output logic [31:0]             data_o,
  output logic                    busy_o,
  output logic                    rd_valid,
  output logic                    err_o,
  t05_wb_manager_if.master        wb
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [31:0]   data_q, data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (wr_en || r_en) begin
          adr_d   = addr;
          dat_d   = data_i;
          sel_d   = select;
          we_d    = wr_en;  // write wins when both are requested
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // we_q still identifies the operation here; it is cleared on exit.
        if (wb.ACK_I) begin
          we_d    = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            data_d     = wb.DAT_I;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (!we_q) begin
            data_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == BUS);
  assign data_o   = data_q;
  assign rd_valid = rd_valid_q;
  assign err_o    = err_q;

  assign wb.ADR_O = adr_q;
  assign wb.DAT_O = dat_q;
  assign wb.SEL_O = sel_q;
  assign wb.WE_O  = we_q;
  assign wb.CYC_O = (state_q == BUS);
  assign wb.STB_O = (state_q == BUS);

endmodule

// File: tb/tb_t05_wb_manager.sv
// Randomised bench for t05_wb_manager; the bench plays the Wishbone slave and
// predicts each transaction's outcome from the request/ACK/timeout rules.
module tb_t05_wb_manager;
  localparam int          TMO = 8;
  localparam logic [31:0] ERRV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        r_en = 1'b0;
  logic [3:0]  select = '0;
  logic [31:0] addr = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        busy_o;
  logic        rd_valid;
  logic        err_o;

  int total = 0;
  int bad = 0;
  logic [31:0] model_data = '0;

  t05_wb_manager_if wb_bus ();

  t05_wb_manager #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRV)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .r_en     (r_en),
    .select   (select),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .busy_o   (busy_o),
    .rd_valid (rd_valid),
    .err_o    (err_o),
    .wb       (wb_bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction; ack_dly = BUS edge on which ACK is given (0 = never).
  task automatic do_txn(input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int ack_dly, input logic [31:0] rdata);
    bit is_rd, tmo, done;
    int exp_busy, k;
    is_rd    = !we;
    tmo      = (ack_dly == 0) || (ack_dly > TMO);
    exp_busy = tmo ? TMO : ack_dly;

    @(negedge clk);
    wr_en = we; r_en = re; addr = a; data_i = d; select = s;
    wb_bus.ACK_I = 1'b0;
    @(posedge clk); #1;
    check_val("start_busy", 32'(busy_o), 32'd1);
    check_val("start_cyc", 32'(wb_bus.CYC_O), 32'd1);
    check_val("start_stb", 32'(wb_bus.STB_O), 32'd1);
    check_val("start_adr", wb_bus.ADR_O, a);
    check_val("start_dat", wb_bus.DAT_O, d);
    check_val("start_sel", 32'(wb_bus.SEL_O), 32'(s));
    check_val("start_we", 32'(wb_bus.WE_O), 32'(we));
    check_val("start_rdv", 32'(rd_valid), 32'd0);
    check_val("start_err", 32'(err_o), 32'd0);
    // Drop the request and scramble inputs: BUS must ignore them.
    wr_en = 1'b0; r_en = 1'b0;
    addr = 32'h33000000; data_i = $urandom; select = 4'($urandom);

    k = 0; done = 0;
    while (!done && k < 20) begin
      k++;
      @(negedge clk);
      wb_bus.ACK_I = (k == ack_dly);
      wb_bus.DAT_I = (k == ack_dly) ? rdata : $urandom;
      @(posedge clk); #1;
      if (busy_o === 1'b0) done = 1;
      else begin
        check_val("hold_adr", wb_bus.ADR_O, a);
        check_val("hold_we", 32'(wb_bus.WE_O), 32'(we));
        check_val("hold_pulse", 32'({rd_valid, err_o}), 32'd0);
      end
    end
    wb_bus.ACK_I = 1'b0;

    if (is_rd) model_data = tmo ? ERRV : rdata;
    check_val("busy_cycles", 32'(k), 32'(exp_busy));
    check_val("end_data", data_o, model_data);
    check_val("end_rdv", 32'(rd_valid), 32'(is_rd && !tmo));
    check_val("end_err", 32'(err_o), 32'(tmo));
    check_val("end_cyc_stb_we", 32'({wb_bus.CYC_O, wb_bus.STB_O, wb_bus.WE_O}), 32'd0);
    check_val("end_adr", wb_bus.ADR_O, a);
    $display("txn we=%0d adr=%h ack_dly=%0d busy=%0d data_o=%h", we, a, ack_dly, k, data_o);
  endtask

  initial begin
    int acks;
    logic [31:0] wa;
    wb_bus.ACK_I = 1'b0;
    wb_bus.DAT_I = '0;

    #12;
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_bus", 32'({wb_bus.CYC_O, wb_bus.STB_O, wb_bus.WE_O}), 32'd0);
    check_val("rst_adr", wb_bus.ADR_O, 32'd0);
    check_val("rst_data", data_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single write, ACK after 3; single read, ACK after 1.
    do_txn(1, 0, 32'h33000010, 32'h000000AB, 4'hF, 3, 32'h0);
    do_txn(0, 1, 32'h33001024, 32'h0, 4'hF, 1, 32'h12345678);

    // Reset in the middle of a read: everything clears without a clock edge.
    @(negedge clk); r_en = 1'b1; addr = 32'h33000040;
    @(posedge clk); #1; r_en = 1'b0;
    check_val("mid_busy", 32'(busy_o), 32'd1);
    @(negedge clk); #2; rst = 1'b1; #1;
    check_val("arst_bus", 32'({wb_bus.CYC_O, wb_bus.STB_O, busy_o}), 32'd0);
    check_val("arst_data", data_o, 32'd0);
    check_val("arst_pulse", 32'({rd_valid, err_o}), 32'd0);
    check_val("arst_adr", wb_bus.ADR_O, 32'd0);
    model_data = '0;
    @(negedge clk); rst = 1'b0;
    $display("txn reset mid-cycle data_o=%h", data_o);

    // Write priority, timeout, recovery, ACK exactly at the limit.
    do_txn(1, 1, 32'h33000020, 32'h55AA55AA, 4'h3, 2, 32'hFFFFFFFF);
    do_txn(0, 1, 32'h33000030, 32'h0, 4'hF, 0, 32'h0);
    do_txn(0, 1, 32'h33000034, 32'h0, 4'hF, 2, 32'hCAFEF00D);
    do_txn(0, 1, 32'h33000038, 32'h0, 4'hF, TMO, 32'h0BADC0DE);
    do_txn(1, 0, 32'h3300003C, 32'h11111111, 4'h1, 0, 32'h0);

    // ACK in IDLE must be ignored.
    @(negedge clk); wb_bus.ACK_I = 1'b1; wb_bus.DAT_I = 32'h77777777;
    @(posedge clk); #1; wb_bus.ACK_I = 1'b0;
    check_val("idle_ack_busy", 32'(busy_o), 32'd0);
    check_val("idle_ack_data", data_o, model_data);
    check_val("idle_ack_rdv", 32'(rd_valid), 32'd0);

    // Randomised transactions, back to back.
    for (int i = 0; i < 40; i++) begin
      bit w;
      w = $urandom_range(0, 1) == 1;
      do_txn(w, !w || ($urandom_range(0, 1) == 1), $urandom, $urandom,
             4'($urandom), int'($urandom_range(0, 10)), $urandom);
    end

    // Held-write wipe: 2048 words, ACK on the second BUS edge.
    acks = 0;
    wr_en = 1'b1; r_en = 1'b0; select = 4'hF;
    for (int i = 0; i < 2048; i++) begin
      wa = 32'h33000000 + 32'(i * 4);
      @(negedge clk); addr = wa; data_i = $urandom; wb_bus.ACK_I = 1'b0;
      @(posedge clk); #1;
      check_val("wipe_adr", wb_bus.ADR_O, wa);
      check_val("wipe_start", 32'({busy_o, wb_bus.WE_O}), 32'd3);
      @(negedge clk); wb_bus.ACK_I = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); wb_bus.ACK_I = 1'b1;
      if (wb_bus.CYC_O && wb_bus.STB_O && wb_bus.WE_O) acks++;
      @(posedge clk); #1; wb_bus.ACK_I = 1'b0;
      check_val("wipe_done", 32'(busy_o), 32'd0);
    end
    wr_en = 1'b0;
    check_val("wipe_acks", 32'(acks), 32'd2048);
    check_val("wipe_data", data_o, model_data);
    $display("txn wipe acks=%0d", acks);

    @(posedge clk); #1;
    check_val("final_idle", 32'({busy_o, rd_valid, err_o}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
